sd_int_status_ctrl: RTL and testbench
=====================================

// Module: sd_int_status_ctrl
// PURPOSE
// - SD host Normal (030h) and Error (032h) Interrupt Status registers with sticky latching, write-1-to-clear,
//   status-enable masking, signal-enable gating and a registered interrupt line to the host bus.
// - Sits between the command/data engines (event pulses) and the host register interface (W1C writes).
// PARAMETERS
// - WIDTH       16       normal status width
// - ERR_WIDTH   16       error status width
// - ERR_BIT     15       index of the error-summary bit in the normal status
// - RSVD_MASK   16'h7E00 reserved normal bits; always read 0, never set
// - LEVEL_MASK  16'h0100 level-type normal bits (card interrupt); follow source, not sticky, not clearable
// PORTS
// - clk            in   1          single clock
// - rst            in   1          synchronous active-high reset
// - evt_in         in   WIDTH      normal event sources (pulse or level)
// - err_evt_in     in   ERR_WIDTH  error event pulses
// - stat_en        in   WIDTH      normal status enable (034h)
// - err_stat_en    in   ERR_WIDTH  error status enable (036h)
// - sig_en         in   WIDTH      normal signal enable (038h)
// - err_sig_en     in   ERR_WIDTH  error signal enable (03Ah)
// - wr_en          in   1          W1C write strobe, one cycle per write
// - wr_sel         in   1          0 = normal register, 1 = error register
// - wr_data        in   WIDTH      W1C data (error write uses [ERR_WIDTH-1:0])
// - ack            out  1          write accepted
// - status_out     out  WIDTH      normal status
// - err_status_out out  ERR_WIDTH  error status
// - irq            out  1          interrupt line to host
// BEHAVIOUR
// - Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
// - Reset: status_out, err_status_out, ack and irq are all 0. A pending ack is dropped.
// - Sticky bit i (not reserved, not level, not ERR_BIT), registered:
//   next = stat_en[i] & (evt_in[i] | (cur[i] & ~clr[i])).
//   clr = wr_data when wr_en & the matching wr_sel, else 0. The error register uses the same rule with err_ inputs.
// - Set wins: an event and a W1C on the same bit in the same cycle leave the bit at 1.
// - Status enable low forces the bit to 0 on the next edge. The bit does not reappear when the enable returns.
// - Level bits: status_out[i] <= evt_in[i] & stat_en[i]. W1C on them is ignored.
// - Reserved bits are held at 0 and ignore writes.
// - ERR_BIT: status_out[ERR_BIT] = |err_status_out, driven combinationally from the error register.
//   W1C on ERR_BIT is ignored. The bit clears only when all error bits are cleared.
// - Latency: an event sampled at edge N is visible in status at N+1.
//   irq <= |(status_out & sig_en) | |(err_status_out & err_sig_en), so irq rises at N+2.
//   irq falls one edge after the last enabled bit clears.
// - ack: registered. It is high for exactly one cycle, the cycle after the edge that sampled wr_en.
//   Back-to-back wr_en cycles give back-to-back ack cycles. No wait states; every write is accepted.
// - wr_en=1 with wr_data=0 still produces ack and changes nothing.
// STRUCTURE
// - Package sd_host_pkg: register offsets (030h..03Ah), RSVD_MASK and LEVEL_MASK defaults, named bit indices
//   (CMD_COMPLETE=0 ... CARD_INT=8, ERR_INT=15, CMD_TIMEOUT_ERR=0 ...).
// - Sub-module sd_w1c_reg #(W, LEVEL_MASK, RSVD_MASK): one sticky/W1C/enable vector.
//   Instantiated once for the normal register and once for the error register.
// - Top level holds the ERR_BIT summary, the irq register and the ack register.
// TESTING
// - Reset: rst=1 with all evt_in=1 for 2 cycles -> status_out=0, err_status_out=0, irq=0, ack=0.
// - Sticky + W1C: stat_en=sig_en=16'hFFFF, evt_in[0] pulsed 1 cycle at N
//   -> status_out=16'h0001 at N+1 and held, irq=1 at N+2.
//   Then wr_en, wr_sel=0, wr_data=16'h0001 -> ack=1 for one cycle, status_out=0, irq=0 one edge later.
// - Set wins: evt_in[1] pulsed in the same cycle as a W1C of 16'h0002 -> status_out[1] stays 1, ack=1.
// - Error summary: err_evt_in[2] pulsed -> err_status_out=16'h0004 and status_out[15]=1.
//   W1C 16'h8000 on normal -> status_out[15] stays 1.
//   W1C 16'h0004 on error -> both registers read 0.
// - Masking: stat_en[5]=0 with evt_in[5] pulsed -> status_out[5]=0.
//   stat_en[4]=1, sig_en[4]=0, evt_in[4] pulsed -> status_out[4]=1, irq=0.
//   Setting sig_en[4]=1 -> irq=1 next edge.
// - Level/reserved: evt_in[8] held 1 -> status_out[8]=1, and W1C 16'h0100 leaves it at 1.
//   Releasing evt_in[8] -> 0 next edge.
//   evt_in=16'h7E00 -> status_out stays 0.
//   rst asserted mid-write (wr_en=1) -> ack=0 next cycle.

Source files
------------

// File: rtl/sd_host_pkg.sv
// ---------------------------------------------------------------------------
// sd_host_pkg
// Shared constants for the SD host interrupt status block: register offsets,
// default reserved/level masks, the write-select encoding and named bit
// indices for the Normal and Error Interrupt Status registers.
// ---------------------------------------------------------------------------
package sd_host_pkg;

  // Register widths and the position of the error-summary bit
  localparam int SD_WIDTH     = 16;
  localparam int SD_ERR_WIDTH = 16;
  localparam int SD_ERR_BIT   = 15;

  // Host register offsets
  localparam logic [7:0] OFS_NORM_INT_STAT     = 8'h30;
  localparam logic [7:0] OFS_ERR_INT_STAT      = 8'h32;
  localparam logic [7:0] OFS_NORM_INT_STAT_EN  = 8'h34;
  localparam logic [7:0] OFS_ERR_INT_STAT_EN   = 8'h36;
  localparam logic [7:0] OFS_NORM_INT_SIG_EN   = 8'h38;
  localparam logic [7:0] OFS_ERR_INT_SIG_EN    = 8'h3A;

  // Default masks for the normal register
  localparam logic [15:0] SD_RSVD_MASK  = 16'h7E00;
  localparam logic [15:0] SD_LEVEL_MASK = 16'h0100;

  // Write-select encoding
  localparam logic WR_SEL_NORMAL = 1'b0;
  localparam logic WR_SEL_ERROR  = 1'b1;

  // Normal status bit indices
  localparam int CMD_COMPLETE   = 0;
  localparam int XFER_COMPLETE  = 1;
  localparam int BLK_GAP_EVENT  = 2;
  localparam int DMA_INT        = 3;
  localparam int BUF_WR_READY   = 4;
  localparam int BUF_RD_READY   = 5;
  localparam int CARD_INSERT    = 6;
  localparam int CARD_REMOVE    = 7;
  localparam int CARD_INT       = 8;
  localparam int ERR_INT        = 15;

  // Error status bit indices
  localparam int CMD_TIMEOUT_ERR  = 0;
  localparam int CMD_CRC_ERR      = 1;
  localparam int CMD_END_BIT_ERR  = 2;
  localparam int CMD_INDEX_ERR    = 3;
  localparam int DATA_TIMEOUT_ERR = 4;
  localparam int DATA_CRC_ERR     = 5;
  localparam int DATA_END_BIT_ERR = 6;
  localparam int CUR_LIMIT_ERR    = 7;
  localparam int AUTO_CMD12_ERR   = 8;
  localparam int ADMA_ERR         = 9;

  // One-hot 16-bit mask for a status bit index
  function automatic logic [15:0] bitMask(input int idx);
    logic [15:0] m;
    m = 16'h0001 << idx;
    return m;
  endfunction

endpackage

// File: rtl/sd_int_status_ctrl_if.sv
// ---------------------------------------------------------------------------
// sd_int_status_ctrl_if
// Host-side register bus of the interrupt status block.
//   wr_en / wr_sel / wr_data : W1C write (master -> slave)
//   ack                      : write accepted, one cycle per write
//   status_out/err_status_out: current status registers
//   irq                      : interrupt line to the host
// ---------------------------------------------------------------------------
interface sd_int_status_ctrl_if
  import sd_host_pkg::*;
#(
  parameter int WIDTH     = SD_WIDTH,
  parameter int ERR_WIDTH = SD_ERR_WIDTH
);
  logic                 wr_en;
  logic                 wr_sel;
  logic [WIDTH-1:0]     wr_data;
  logic                 ack;
  logic [WIDTH-1:0]     status_out;
  logic [ERR_WIDTH-1:0] err_status_out;
  logic                 irq;

  modport master (
    output wr_en, wr_sel, wr_data,
    input  ack, status_out, err_status_out, irq
  );

  modport slave (
    input  wr_en, wr_sel, wr_data,
    output ack, status_out, err_status_out, irq
  );
endinterface

// File: rtl/sd_w1c_reg.sv
// ---------------------------------------------------------------------------
// sd_w1c_reg
// One interrupt status vector: sticky bits with write-1-to-clear, level bits
// that follow their source, and reserved bits held at 0. Every bit is gated
// by its status enable; set has priority over clear.
//   clk, rst : clock, synchronous active-high reset
//   evtIn    : event sources
//   statEn   : status enable per bit
//   clr      : W1C clear mask (already qualified by the write strobe)
//   status   : registered status vector
// ---------------------------------------------------------------------------
module sd_w1c_reg
  import sd_host_pkg::*;
#(
  parameter int           W          = 16,
  parameter logic [W-1:0] LEVEL_MASK = {W{1'b0}},
  parameter logic [W-1:0] RSVD_MASK  = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] evtIn,
  input  logic [W-1:0] statEn,
  input  logic [W-1:0] clr,
  output logic [W-1:0] status
);

  logic [W-1:0] statusR;
  logic [W-1:0] statusNextS;
  logic [W-1:0] stickyNextS;
  logic [W-1:0] levelNextS;

  // Next-state: sticky bits keep their value unless cleared, events win over clears
  always_comb begin
    stickyNextS = statEn & (evtIn | (statusR & ~clr));
    levelNextS  = statEn & evtIn;
    statusNextS = ~RSVD_MASK & ((LEVEL_MASK & levelNextS) | (~LEVEL_MASK & stickyNextS));
  end

  // Status register
  always_ff @(posedge clk) begin
    if (rst) begin
      statusR <= {W{1'b0}};
    end else begin
      statusR <= statusNextS;
    end
  end

  assign status = statusR;

endmodule

// File: rtl/sd_int_status_ctrl.sv
// ---------------------------------------------------------------------------
// sd_int_status_ctrl
// SD host Normal (030h) and Error (032h) Interrupt Status registers with
// sticky latching, W1C, status-enable masking, signal-enable gating and a
// registered interrupt line.
//   clk, rst    : clock, synchronous active-high reset
//   evt_in      : normal event sources (pulse or level)
//   err_evt_in  : error event pulses
//   stat_en     : normal status enable (034h)
//   err_stat_en : error status enable (036h)
//   sig_en      : normal signal enable (038h)
//   err_sig_en  : error signal enable (03Ah)
//   bus         : host register bus (W1C write, ack, status, irq)
// ---------------------------------------------------------------------------
module sd_int_status_ctrl
  import sd_host_pkg::*;
#(
  parameter int               WIDTH      = SD_WIDTH,
  parameter int               ERR_WIDTH  = SD_ERR_WIDTH,
  parameter int               ERR_BIT    = SD_ERR_BIT,
  parameter logic [WIDTH-1:0] RSVD_MASK  = SD_RSVD_MASK,
  parameter logic [WIDTH-1:0] LEVEL_MASK = SD_LEVEL_MASK
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     evt_in,
  input  logic [ERR_WIDTH-1:0] err_evt_in,
  input  logic [WIDTH-1:0]     stat_en,
  input  logic [ERR_WIDTH-1:0] err_stat_en,
  input  logic [WIDTH-1:0]     sig_en,
  input  logic [ERR_WIDTH-1:0] err_sig_en,
  sd_int_status_ctrl_if.slave  bus
);

  // The summary bit is driven from the error register, so the normal vector
  // holds it at 0 like a reserved bit and the top ORs the summary in.
  localparam logic [WIDTH-1:0] ERR_BIT_MASK   = {{(WIDTH-1){1'b0}}, 1'b1} << ERR_BIT;
  localparam logic [WIDTH-1:0] NORM_HOLD_MASK = RSVD_MASK | ERR_BIT_MASK;

  logic [WIDTH-1:0]     normClrS;
  logic [ERR_WIDTH-1:0] errClrS;
  logic [WIDTH-1:0]     normStatusS;
  logic [ERR_WIDTH-1:0] errStatusS;
  logic [WIDTH-1:0]     statusS;
  logic                 errSummaryS;
  logic                 irqNextS;
  logic                 irqR;
  logic                 ackR;

  // Route the W1C data to the register selected by wr_sel
  always_comb begin
    normClrS = {WIDTH{1'b0}};
    errClrS  = {ERR_WIDTH{1'b0}};
    if (bus.wr_en && (bus.wr_sel == WR_SEL_NORMAL)) begin
      normClrS = bus.wr_data;
    end else if (bus.wr_en && (bus.wr_sel == WR_SEL_ERROR)) begin
      errClrS = bus.wr_data[ERR_WIDTH-1:0];
    end else begin
      normClrS = {WIDTH{1'b0}};
      errClrS  = {ERR_WIDTH{1'b0}};
    end
  end

  sd_w1c_reg #(
    .W          (WIDTH),
    .LEVEL_MASK (LEVEL_MASK),
    .RSVD_MASK  (NORM_HOLD_MASK)
  ) uNormReg (
    .clk    (clk),
    .rst    (rst),
    .evtIn  (evt_in),
    .statEn (stat_en),
    .clr    (normClrS),
    .status (normStatusS)
  );

  sd_w1c_reg #(
    .W          (ERR_WIDTH),
    .LEVEL_MASK ({ERR_WIDTH{1'b0}}),
    .RSVD_MASK  ({ERR_WIDTH{1'b0}})
  ) uErrReg (
    .clk    (clk),
    .rst    (rst),
    .evtIn  (err_evt_in),
    .statEn (err_stat_en),
    .clr    (errClrS),
    .status (errStatusS)
  );

  // Error summary and interrupt request from the enabled status bits
  always_comb begin
    errSummaryS = |errStatusS;
    statusS     = normStatusS | (errSummaryS ? ERR_BIT_MASK : {WIDTH{1'b0}});
    irqNextS    = (|(statusS & sig_en)) | (|(errStatusS & err_sig_en));
  end

  // Registered interrupt line and write acknowledge
  always_ff @(posedge clk) begin
    if (rst) begin
      irqR <= 1'b0;
      ackR <= 1'b0;
    end else begin
      irqR <= irqNextS;
      ackR <= bus.wr_en;
    end
  end

  assign bus.status_out     = statusS;
  assign bus.err_status_out = errStatusS;
  assign bus.irq            = irqR;
  assign bus.ack            = ackR;

endmodule

// File: tb/tb_sd_int_status_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sd_int_status_ctrl
// Directed bench for sd_int_status_ctrl with hand-computed expected values.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_sd_int_status_ctrl;
  import sd_host_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] evt_in;
  logic [15:0] err_evt_in;
  logic [15:0] stat_en;
  logic [15:0] err_stat_en;
  logic [15:0] sig_en;
  logic [15:0] err_sig_en;

  int checkCnt;
  int passCnt;

  sd_int_status_ctrl_if #(.WIDTH(16), .ERR_WIDTH(16)) busIf ();

  sd_int_status_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .evt_in      (evt_in),
    .err_evt_in  (err_evt_in),
    .stat_en     (stat_en),
    .err_stat_en (err_stat_en),
    .sig_en      (sig_en),
    .err_sig_en  (err_sig_en),
    .bus         (busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expected value
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs === exp) begin
      passCnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic w1c(input logic sel, input logic [15:0] data);
    busIf.wr_en   = 1'b1;
    busIf.wr_sel  = sel;
    busIf.wr_data = data;
  endtask

  task automatic wrIdle();
    busIf.wr_en   = 1'b0;
    busIf.wr_sel  = 1'b0;
    busIf.wr_data = 16'h0000;
  endtask

  initial begin
    checkCnt = 0;
    passCnt  = 0;
    rst         = 1'b1;
    evt_in      = 16'hFFFF;
    err_evt_in  = 16'hFFFF;
    stat_en     = 16'hFFFF;
    err_stat_en = 16'hFFFF;
    sig_en      = 16'hFFFF;
    err_sig_en  = 16'hFFFF;
    wrIdle();

    // Reset with all events asserted
    tick();
    tick();
    checkVal("rst_status", {16'h0, busIf.status_out}, 32'h0);
    checkVal("rst_err", {16'h0, busIf.err_status_out}, 32'h0);
    checkVal("rst_irq", {31'h0, busIf.irq}, 32'h0);
    checkVal("rst_ack", {31'h0, busIf.ack}, 32'h0);

    rst        = 1'b0;
    evt_in     = 16'h0000;
    err_evt_in = 16'h0000;
    tick();
    tick();
    checkVal("idle_status", {16'h0, busIf.status_out}, 32'h0);

    // Sticky event on bit 0 and its latency to irq
    evt_in = 16'h0001;
    tick();
    evt_in = 16'h0000;
    checkVal("sticky_set", {16'h0, busIf.status_out}, 32'h0001);
    checkVal("irq_not_yet", {31'h0, busIf.irq}, 32'h0);
    tick();
    checkVal("sticky_hold", {16'h0, busIf.status_out}, 32'h0001);
    checkVal("irq_rise", {31'h0, busIf.irq}, 32'h1);

    // W1C of bit 0
    w1c(WR_SEL_NORMAL, 16'h0001);
    tick();
    wrIdle();
    checkVal("w1c_ack", {31'h0, busIf.ack}, 32'h1);
    checkVal("w1c_status", {16'h0, busIf.status_out}, 32'h0);
    tick();
    checkVal("w1c_ack_drop", {31'h0, busIf.ack}, 32'h0);
    checkVal("w1c_irq_fall", {31'h0, busIf.irq}, 32'h0);

    // Set wins over a clear in the same cycle
    evt_in = 16'h0002;
    w1c(WR_SEL_NORMAL, 16'h0002);
    tick();
    evt_in = 16'h0000;
    wrIdle();
    checkVal("setwin_status", {16'h0, busIf.status_out}, 32'h0002);
    checkVal("setwin_ack", {31'h0, busIf.ack}, 32'h1);
    tick();
    checkVal("setwin_hold", {16'h0, busIf.status_out}, 32'h0002);
    w1c(WR_SEL_NORMAL, 16'h0002);
    tick();
    wrIdle();
    checkVal("setwin_clear", {16'h0, busIf.status_out}, 32'h0);
    tick();

    // Error summary
    err_evt_in = 16'h0004;
    tick();
    err_evt_in = 16'h0000;
    checkVal("err_set", {16'h0, busIf.err_status_out}, 32'h0004);
    checkVal("err_summary", {16'h0, busIf.status_out}, 32'h8000);
    w1c(WR_SEL_NORMAL, 16'h8000);
    tick();
    wrIdle();
    checkVal("summary_w1c_ign", {16'h0, busIf.status_out}, 32'h8000);
    checkVal("summary_w1c_ack", {31'h0, busIf.ack}, 32'h1);
    w1c(WR_SEL_ERROR, 16'h0004);
    tick();
    wrIdle();
    checkVal("err_clear", {16'h0, busIf.err_status_out}, 32'h0);
    checkVal("summary_clear", {16'h0, busIf.status_out}, 32'h0);
    tick();
    tick();
    checkVal("err_irq_fall", {31'h0, busIf.irq}, 32'h0);

    // Status enable masking
    stat_en = 16'hFFDF;
    evt_in  = 16'h0020;
    tick();
    evt_in  = 16'h0000;
    checkVal("stat_en_mask", {16'h0, busIf.status_out}, 32'h0);
    stat_en = 16'hFFFF;

    // Signal enable gating
    sig_en = 16'hFFEF;
    evt_in = 16'h0010;
    tick();
    evt_in = 16'h0000;
    tick();
    tick();
    checkVal("sig_mask_status", {16'h0, busIf.status_out}, 32'h0010);
    checkVal("sig_mask_irq", {31'h0, busIf.irq}, 32'h0);
    sig_en = 16'hFFFF;
    tick();
    checkVal("sig_en_irq", {31'h0, busIf.irq}, 32'h1);

    // Dropping the status enable clears the bit; it does not come back
    stat_en = 16'hFFEF;
    tick();
    checkVal("en_drop_clear", {16'h0, busIf.status_out}, 32'h0);
    stat_en = 16'hFFFF;
    tick();
    checkVal("en_return", {16'h0, busIf.status_out}, 32'h0);

    // Level bit follows the source and ignores W1C
    evt_in = 16'h0100;
    tick();
    checkVal("level_set", {16'h0, busIf.status_out}, 32'h0100);
    w1c(WR_SEL_NORMAL, 16'h0100);
    tick();
    wrIdle();
    checkVal("level_w1c_ign", {16'h0, busIf.status_out}, 32'h0100);
    evt_in = 16'h0000;
    tick();
    checkVal("level_release", {16'h0, busIf.status_out}, 32'h0);

    // Reserved bits never set
    evt_in = 16'h7E00;
    tick();
    tick();
    evt_in = 16'h0000;
    checkVal("rsvd_status", {16'h0, busIf.status_out}, 32'h0);

    // Zero-data write still acked
    w1c(WR_SEL_NORMAL, 16'h0000);
    tick();
    checkVal("zero_wr_ack", {31'h0, busIf.ack}, 32'h1);
    checkVal("zero_wr_status", {16'h0, busIf.status_out}, 32'h0);

    // Back-to-back writes give back-to-back acks
    w1c(WR_SEL_ERROR, 16'h0000);
    tick();
    checkVal("b2b_ack", {31'h0, busIf.ack}, 32'h1);
    wrIdle();
    tick();
    checkVal("b2b_ack_end", {31'h0, busIf.ack}, 32'h0);

    // Reset during a write drops ack and status
    evt_in = 16'h0001;
    tick();
    evt_in = 16'h0000;
    checkVal("pre_rst_status", {16'h0, busIf.status_out}, 32'h0001);
    rst = 1'b1;
    w1c(WR_SEL_NORMAL, 16'h0000);
    tick();
    checkVal("rst_wr_ack", {31'h0, busIf.ack}, 32'h0);
    checkVal("rst_wr_status", {16'h0, busIf.status_out}, 32'h0);
    rst = 1'b0;
    wrIdle();
    tick();

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
